wb_cmd_initiator: RTL and testbench
===================================

Name: wb_cmd_initiator

Overview:
Wishbone classic initiator that turns single register-access commands into bus cycles towards the syscon register slave and other 32-bit peripheral slaves. Commands arrive on a valid/ready handshake from a debug bridge or boot sequencer, and results return on a second valid/ready handshake. Only one transaction is ever outstanding. A timeout counter guards against slaves that never acknowledge.

Parameters:
AW, 6, Wishbone address width (word-aligned byte address; bits [1:0] passed through).
TIMEOUT, 255, cycles allowed in the bus phase without ack/err before error termination; legal range 1..65535.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_we  in  1  1=write, 0=read
i_cmd_adr  in  AW  byte address
i_cmd_dat  in  32  write data
i_cmd_sel  in  4  byte enables
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  response consumed when valid&ready
o_rsp_dat  out  32  read data (0 for writes and errors)
o_rsp_err  out  1  1 = slave err or timeout
o_wb_adr  out  AW  bus address
o_wb_dat  out  32  bus write data
o_wb_sel  out  4  bus byte enables
o_wb_we  out  1  bus write enable
o_wb_cyc  out  1  bus cycle
o_wb_stb  out  1  bus strobe
i_wb_rdt  in  32  slave read data
i_wb_ack  in  1  slave acknowledge
i_wb_err  in  1  slave error (tie 0 for slaves without err)

Behaviour:
- State machine: IDLE, BUS, RESP. All outputs are registered.
- Reset values (synchronous, takes priority over every other condition):
  - state=IDLE; timer=0.
  - o_wb_cyc=0, o_wb_stb=0, o_wb_we=0.
  - o_wb_adr=0, o_wb_dat=0, o_wb_sel=0.
  - o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0.
- o_cmd_ready = (state==IDLE) & !i_rst. It is combinational from state, so it is 1 in the first cycle after reset.
- IDLE:
  - On i_cmd_valid&o_cmd_ready, latch adr/dat/sel/we into o_wb_*.
  - Set o_wb_cyc=o_wb_stb=1 and timer=0, then go to BUS.
  - The bus is asserted in the cycle after acceptance.
- BUS:
  - cyc/stb stay high and o_wb_adr/dat/sel/we stay stable until termination.
  - timer increments by 1 each cycle; timer width is $clog2(TIMEOUT+1).
  - Termination priority, evaluated each cycle:
    1. i_wb_err → o_rsp_err=1, o_rsp_dat=0.
    2. i_wb_ack → o_rsp_err=0; o_rsp_dat=i_wb_rdt for a read, 0 for a write.
    3. timer==TIMEOUT-1 with no ack/err → o_rsp_err=1, o_rsp_dat=0.
  - On termination: cyc=stb=0 at the next edge, o_rsp_valid=1, go to RESP.
  - ack and err in the same cycle count as err.
  - ack on the final timeout cycle counts as ack.
- RESP:
  - o_rsp_valid stays 1 and o_rsp_dat/o_rsp_err stay stable until i_rsp_ready.
  - On i_rsp_ready: o_rsp_valid=0, go to IDLE. The next command can be accepted one cycle later; no command is accepted while in RESP.
- ack/err arriving outside BUS (late or spurious) is ignored and corrupts no state.
- Latency with a slave that acks one cycle after cyc (the syscon behaviour):
  - command accepted at edge T;
  - cyc/stb high after T;
  - ack sampled at T+2;
  - rsp_valid high after T+2, i.e. visible in cycle T+3.
- Reset mid-operation (BUS or RESP): cyc/stb drop at the reset edge; any pending response is discarded with no rsp_valid pulse.
- The command inputs are not sampled outside IDLE. The upstream side must hold i_cmd_* stable while valid is high and ready is low (standard valid/ready).

Test Plan:
- Read: cmd adr=0x00, we=0, slave acks 1 cycle after cyc with rdt=0x01FFFFFF → rsp_valid exactly 3 cycles after acceptance, rsp_dat=0x01FFFFFF, rsp_err=0, cyc high exactly 2 cycles.
- Write then readback: write adr=0x0C dat=0x80000100 sel=0xF → rsp_dat=0, err=0; read of 0x0C returns 0x80000100. Also check byte write sel=0x1 dat=0xAB is presented unchanged on o_wb_sel/o_wb_dat.
- Timeout: TIMEOUT=4, slave never acks → cyc high exactly 4 cycles, rsp_err=1, rsp_dat=0. An ack injected 2 cycles later is ignored, state stays IDLE.
- Backpressure: hold i_rsp_ready=0 for 10 cycles → rsp_valid/dat/err stable, cmd_ready=0 throughout, no second bus cycle. Second command accepted 1 cycle after rsp handshake.
- Error priority: ack and err asserted together → rsp_err=1. Separately, ack on the final timeout cycle (TIMEOUT-1) → rsp_err=0 with valid data.
- Reset mid-BUS: assert i_rst while cyc=1 → cyc/stb/rsp_valid all 0 after the edge, cmd_ready=1 the following cycle, next read completes normally.

Source files
------------

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: turns single register-access commands into
// one bus cycle at a time and returns the read data or error status on a
// separate valid/ready response channel. A cycle counter ends bus cycles
// that no slave acknowledges.
module wb_cmd_initiator #(
    parameter int AW      = 6,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_we,
    input  logic [AW-1:0] i_cmd_adr,
    input  logic [31:0]   i_cmd_dat,
    input  logic [3:0]    i_cmd_sel,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_dat,
    output logic          o_rsp_err,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    input  logic          i_wb_err
);

    // Timer only has to reach TIMEOUT-1; one extra count of headroom keeps
    // the increment on the terminating cycle from wrapping.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;

    logic [AW-1:0] adr_nxt;
    logic [31:0]   dat_nxt;
    logic [3:0]    sel_nxt;
    logic          we_nxt;
    logic          cyc_nxt;
    logic          stb_nxt;
    logic          rsp_valid_nxt;
    logic [31:0]   rsp_dat_nxt;
    logic          rsp_err_nxt;

    // Read data is only meaningful for reads; writes report zero.
    function automatic logic [31:0] ack_data(input logic we, input logic [31:0] rdt);
        return we ? 32'd0 : rdt;
    endfunction

    // Ready is a pure function of state so upstream sees it the cycle after
    // reset, but it is masked while reset is held.
    assign o_cmd_ready = (state == IDLE) && !i_rst;

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        adr_nxt       = o_wb_adr;
        dat_nxt       = o_wb_dat;
        sel_nxt       = o_wb_sel;
        we_nxt        = o_wb_we;
        cyc_nxt       = o_wb_cyc;
        stb_nxt       = o_wb_stb;
        rsp_valid_nxt = o_rsp_valid;
        rsp_dat_nxt   = o_rsp_dat;
        rsp_err_nxt   = o_rsp_err;

        case (state)
            IDLE: begin
                if (i_cmd_valid && o_cmd_ready) begin
                    adr_nxt   = i_cmd_adr;
                    dat_nxt   = i_cmd_dat;
                    sel_nxt   = i_cmd_sel;
                    we_nxt    = i_cmd_we;
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = BUS;
                end
            end

            BUS: begin
                timer_nxt = timer + TW'(1);
                // err beats ack; ack on the last timer cycle still wins
                // over the timeout.
                if (i_wb_err) begin
                    rsp_err_nxt   = 1'b1;
                    rsp_dat_nxt   = 32'd0;
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (i_wb_ack) begin
                    rsp_err_nxt   = 1'b0;
                    rsp_dat_nxt   = ack_data(o_wb_we, i_wb_rdt);
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (timer == TIMER_LAST) begin
                    rsp_err_nxt   = 1'b1;
                    rsp_dat_nxt   = 32'd0;
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end

            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and timer register; reset wins over everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Registered bus and response outputs; reset drops cyc/stb and
    // discards any pending response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_adr    <= '0;
            o_wb_dat    <= 32'd0;
            o_wb_sel    <= 4'd0;
            o_wb_we     <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_dat   <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_wb_adr    <= adr_nxt;
            o_wb_dat    <= dat_nxt;
            o_wb_sel    <= sel_nxt;
            o_wb_we     <= we_nxt;
            o_wb_cyc    <= cyc_nxt;
            o_wb_stb    <= stb_nxt;
            o_rsp_valid <= rsp_valid_nxt;
            o_rsp_dat   <= rsp_dat_nxt;
            o_rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: a small register-file slave with programmable
// ack delay and error injection, a vector table of single commands, and
// hand-written sequences for spurious acks, backpressure and mid-bus reset.
module tb_wb_cmd_initiator;

    localparam int AW = 6;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [31:0]   cmd_dat = 32'd0;
    logic [3:0]    cmd_sel = 4'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_dat;
    logic          rsp_err;
    logic [AW-1:0] wb_adr;
    logic [31:0]   wb_dat;
    logic [3:0]    wb_sel;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_stb;
    logic [31:0]   wb_rdt;
    logic          wb_ack;
    logic          wb_err;

    int checks = 0;
    int errors = 0;

    // slave model controls
    int   dly = 1;
    bit   err_en = 1'b0;
    bit   force_ack = 1'b0;
    bit   force_err = 1'b0;
    int   cnt;
    logic [31:0] mem [16];
    logic slv_hit;

    always #5 clk = ~clk;

    wb_cmd_initiator #(.AW(AW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_we(cmd_we), .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_dat(rsp_dat), .o_rsp_err(rsp_err),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .i_wb_err(wb_err)
    );

    assign slv_hit = wb_cyc && wb_stb && (cnt == dly);
    assign wb_ack  = slv_hit || force_ack;
    assign wb_err  = (slv_hit && err_en) || force_err;
    assign wb_rdt  = mem[wb_adr[5:2]];

    // slave: counts cycles of cyc, writes bytes on a clean ack
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h01FF_FFFF;
        end else begin
            cnt <= wb_cyc ? cnt + 1 : 0;
            if (wb_cyc && wb_stb && wb_we && wb_ack && !wb_err)
                for (int b = 0; b < 4; b++)
                    if (wb_sel[b]) mem[wb_adr[5:2]][8*b +: 8] <= wb_dat[8*b +: 8];
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // wait (bounded) for rsp_valid, counting cycles since acceptance and cyc cycles
    task automatic wait_rsp(output int lat, output int ncyc);
        bit done;
        done = 1'b0;
        lat  = 0;
        ncyc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            lat++;
            if (wb_cyc) ncyc++;
            if (rsp_valid) done = 1'b1;
            else @(negedge clk);
        end
        check1("rsp_arrives", rsp_valid, 1'b1);
    endtask

    // one full command: issue, check bus fields, wait, capture, handshake
    task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic rerr,
                           output int lat, output int ncyc);
        @(negedge clk);
        check1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        check1("bus_cyc", wb_cyc, 1'b1);
        check1("bus_stb", wb_stb, 1'b1);
        check32("bus_adr", 32'(wb_adr), 32'(adr));
        check32("bus_dat", wb_dat, dat);
        check32("bus_sel", 32'(wb_sel), 32'(sel));
        check1("bus_we", wb_we, we);
        wait_rsp(lat, ncyc);
        rdat = rsp_dat;
        rerr = rsp_err;
        check1("rsp_cyc_low", wb_cyc, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check1("rsp_valid_drop", rsp_valid, 1'b0);
        check1("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        int            dly;
        bit            err_en;
        logic [31:0]   exp_dat;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs [12];

    initial begin : main
        logic [31:0] rdat;
        logic        rerr;
        int          lat;
        int          ncyc;

        // dly=7 never matches within TIMEOUT=4, so those vectors time out
        vecs[0]  = '{1'b0, 6'h00, 32'h0,         4'hF, 1, 1'b0, 32'h01FF_FFFF, 1'b0, 3};
        vecs[1]  = '{1'b1, 6'h0C, 32'h8000_0100, 4'hF, 1, 1'b0, 32'h0,         1'b0, 3};
        vecs[2]  = '{1'b0, 6'h0C, 32'h0,         4'hF, 1, 1'b0, 32'h8000_0100, 1'b0, 3};
        vecs[3]  = '{1'b1, 6'h10, 32'h0000_00AB, 4'h1, 1, 1'b0, 32'h0,         1'b0, 3};
        vecs[4]  = '{1'b0, 6'h10, 32'h0,         4'hF, 1, 1'b0, 32'h0000_00AB, 1'b0, 3};
        vecs[5]  = '{1'b1, 6'h14, 32'h1234_5678, 4'h6, 1, 1'b0, 32'h0,         1'b0, 3};
        vecs[6]  = '{1'b0, 6'h14, 32'h0,         4'hF, 1, 1'b0, 32'h0034_5600, 1'b0, 3};
        vecs[7]  = '{1'b0, 6'h00, 32'h0,         4'hF, 3, 1'b0, 32'h01FF_FFFF, 1'b0, 5};
        vecs[8]  = '{1'b0, 6'h00, 32'h0,         4'hF, 7, 1'b0, 32'h0,         1'b1, 5};
        vecs[9]  = '{1'b1, 6'h0C, 32'hDEAD_BEEF, 4'hF, 1, 1'b1, 32'h0,         1'b1, 3};
        vecs[10] = '{1'b0, 6'h0C, 32'h0,         4'hF, 2, 1'b1, 32'h0,         1'b1, 4};
        vecs[11] = '{1'b0, 6'h0C, 32'h0,         4'hF, 0, 1'b0, 32'h8000_0100, 1'b0, 2};

        // reset state
        repeat (3) @(negedge clk);
        check1("rst_cmd_ready", cmd_ready, 1'b0);
        check1("rst_cyc", wb_cyc, 1'b0);
        check1("rst_stb", wb_stb, 1'b0);
        check1("rst_we", wb_we, 1'b0);
        check32("rst_adr", 32'(wb_adr), 32'd0);
        check32("rst_dat", wb_dat, 32'd0);
        check32("rst_sel", 32'(wb_sel), 32'd0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check32("rst_rsp_dat", rsp_dat, 32'd0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("cmd_ready_after_rst", cmd_ready, 1'b1);

        // table of single commands
        for (int v = 0; v < 12; v++) begin
            dly    = vecs[v].dly;
            err_en = vecs[v].err_en;
            run_cmd(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, rdat, rerr, lat, ncyc);
            check32($sformatf("v%0d_rsp_dat", v), rdat, vecs[v].exp_dat);
            check1($sformatf("v%0d_rsp_err", v), rerr, vecs[v].exp_err);
            check32($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check32($sformatf("v%0d_cyc_cycles", v), 32'(ncyc), 32'(vecs[v].exp_lat - 1));
        end
        err_en = 1'b0;

        // timeout, then spurious ack/err two cycles later
        dly = 7;
        run_cmd(1'b0, 6'h04, 32'h0, 4'hF, rdat, rerr, lat, ncyc);
        check1("to_err", rerr, 1'b1);
        check32("to_cyc_cycles", 32'(ncyc), 32'd4);
        @(negedge clk);
        force_ack = 1'b1;
        force_err = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        force_err = 1'b0;
        check1("spur_cyc", wb_cyc, 1'b0);
        check1("spur_rsp_valid", rsp_valid, 1'b0);
        check1("spur_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        check1("spur_cyc2", wb_cyc, 1'b0);
        check1("spur_rsp_valid2", rsp_valid, 1'b0);

        // backpressure: second command held valid while response waits
        dly = 1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 6'h0C; cmd_dat = 32'h0; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_adr = 6'h00;
        wait_rsp(lat, ncyc);
        check32("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1($sformatf("bp_valid_%0d", i), rsp_valid, 1'b1);
            check32($sformatf("bp_dat_%0d", i), rsp_dat, 32'h8000_0100);
            check1($sformatf("bp_err_%0d", i), rsp_err, 1'b0);
            check1($sformatf("bp_cmd_ready_%0d", i), cmd_ready, 1'b0);
            check1($sformatf("bp_cyc_%0d", i), wb_cyc, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check1("bp_valid_drop", rsp_valid, 1'b0);
        check1("bp_cmd_ready", cmd_ready, 1'b1);
        check1("bp_no_cyc_yet", wb_cyc, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check1("bp_second_cyc", wb_cyc, 1'b1);
        check32("bp_second_adr", 32'(wb_adr), 32'h00);
        wait_rsp(lat, ncyc);
        check32("bp_second_dat", rsp_dat, 32'h01FF_FFFF);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // reset while in BUS
        dly = 7;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 6'h10; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check1("mr_cyc_before", wb_cyc, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check1("mr_cyc", wb_cyc, 1'b0);
        check1("mr_stb", wb_stb, 1'b0);
        check1("mr_rsp_valid", rsp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("mr_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1($sformatf("mr_no_rsp_%0d", i), rsp_valid, 1'b0);
        end
        dly = 1;
        run_cmd(1'b0, 6'h00, 32'h0, 4'hF, rdat, rerr, lat, ncyc);
        check32("mr_read_dat", rdat, 32'h01FF_FFFF);
        check1("mr_read_err", rerr, 1'b0);
        check32("mr_read_lat", 32'(lat), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
